cello_lut_pipe: RTL

// - Parametrised successor to the fixed 4-input Cello NOR/NOT logic netlists.
// - Evaluates NUM_CH independent NUM_IN-input boolean functions on one shared input vector.
// - Each function is a runtime-writable truth table (hex convention as in Cello names, e.g. 0x2A56).
// - Evaluation runs through a 2-stage valid/ready pipeline with backpressure.
// - Sits between stimulus sequencers and circuit-scoring logic; replaces one netlist per function.
//

---
 rtl/cello_lut_pipe.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/cello_lut_pipe.sv
// Two-stage valid/ready pipeline evaluating NUM_CH runtime-writable NUM_IN-input truth tables.
// Optional output hysteresis filter enabled by defining CELLO_LUT_FILTER_EN.
module cello_lut_pipe #(
  parameter int unsigned NUM_IN   = 4,
  parameter int unsigned NUM_CH   = 2,
  parameter logic [NUM_CH*(2**NUM_IN)-1:0] TT_INIT = {16'h00FF, 16'h2A56},
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_we,
  // One spare bit so out-of-range channel numbers are representable and can be rejected
  input  logic [$clog2(NUM_CH):0]       cfg_ch,
  input  logic [(2**NUM_IN)-1:0]        cfg_tt,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [NUM_IN-1:0]             in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [NUM_CH-1:0]             out_data,
  output logic [CNT_W-1:0]              xfer_cnt
);

  localparam int unsigned TW   = 2**NUM_IN;
  localparam int unsigned CH_W = $clog2(NUM_CH) + 1;

  if (FILT_LEN < 1) begin : g_filt_len_check
    $error("FILT_LEN must be at least 1");
  end

  logic [TW-1:0]     tt_q [NUM_CH];
  logic              a_full_q;
  logic [NUM_IN-1:0] a_idx_q;
  logic              b_full_q;
  logic [NUM_CH-1:0] b_raw_q;
  logic [CNT_W-1:0]  cnt_q;

  logic              b_free;
  logic              a_adv;
  logic              in_xfer;
  logic              out_xfer;
  logic [NUM_CH-1:0] lookup;

  assign b_free    = !b_full_q || out_ready;
  assign a_adv     = a_full_q && b_free;
  assign in_ready  = !a_full_q || b_free;
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = b_full_q && out_ready;
  assign out_valid = b_full_q;
  assign xfer_cnt  = cnt_q;

  // Lookup reads the registered tables, so a write in the same cycle as A->B sees the old table
  always_comb begin
    lookup = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      lookup[c] = tt_q[c][a_idx_q];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        tt_q[c] <= TT_INIT[c*TW +: TW];
      end
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (cfg_we && (cfg_ch == CH_W'(c))) begin
          tt_q[c] <= cfg_tt;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_full_q <= 1'b0;
      a_idx_q  <= '0;
      b_full_q <= 1'b0;
      b_raw_q  <= '0;
      cnt_q    <= '0;
    end else begin
      if (in_xfer) begin
        a_full_q <= 1'b1;
        a_idx_q  <= in_data;
      end else if (a_adv) begin
        a_full_q <= 1'b0;
      end

      if (a_adv) begin
        b_full_q <= 1'b1;
        b_raw_q  <= lookup;
      end else if (out_xfer) begin
        b_full_q <= 1'b0;
      end

      if (out_xfer && (cnt_q != {CNT_W{1'b1}})) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

`ifdef CELLO_LUT_FILTER_EN
  localparam int unsigned FC_W = $clog2(FILT_LEN + 1);

  logic [NUM_CH-1:0] filt_q;
  logic [FC_W-1:0]   fcnt_q [NUM_CH];
  logic [NUM_CH-1:0] flip;

  // The transfer that completes the disagreement run already presents the new value
  always_comb begin
    flip = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      flip[c] = (b_raw_q[c] != filt_q[c]) && ((32'(fcnt_q[c]) + 32'd1) >= FILT_LEN);
    end
  end

  assign out_data = filt_q ^ flip;

  always_ff @(posedge clk) begin
    if (rst) begin
      filt_q <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        fcnt_q[c] <= '0;
      end
    end else if (out_xfer) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (flip[c]) begin
          filt_q[c] <= b_raw_q[c];
          fcnt_q[c] <= '0;
        end else if (b_raw_q[c] != filt_q[c]) begin
          fcnt_q[c] <= fcnt_q[c] + FC_W'(1);
        end else begin
          fcnt_q[c] <= '0;
        end
      end
    end
  end
`else
  assign out_data = b_raw_q;
`endif

endmodule
